// File: rtl/puf_eval_sequencer.sv
// puf_eval_sequencer: captures a challenge, runs VOTE_N settle/sample/recover
// evaluations of the PUF array, and presents a per-bit majority-voted response
// with an unstable-bit mask through a valid/ack handshake.
module puf_eval_sequencer #(
  parameter int CHAL_W        = 8,
  parameter int RESP_W        = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int VOTE_N        = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic [CHAL_W-1:0] challenge,
  input  logic              ack,
  output logic [CHAL_W-1:0] puf_chal,
  output logic              puf_en,
  input  logic [RESP_W-1:0] puf_resp,
  output logic              busy,
  output logic [RESP_W-1:0] resp,
  output logic [RESP_W-1:0] unstable,
  output logic              resp_valid
);

  typedef enum logic [1:0] {IDLE, SETTLE, RECOVER, DONE} state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0] VOTE_CNT    = 4'(VOTE_N);
  localparam logic [3:0] VOTE_HALF   = 4'(VOTE_N / 2);

  state_t                  state_q, state_d;
  logic [7:0]              settle_cnt_q, settle_cnt_d;
  logic [3:0]              eval_cnt_q, eval_cnt_d;
  logic [RESP_W-1:0][3:0]  vote_q, vote_d;
  logic [RESP_W-1:0][3:0]  vote_inc;
  logic [RESP_W-1:0]       maj_bits, mix_bits;
  logic [CHAL_W-1:0]       puf_chal_q, puf_chal_d;
  logic                    puf_en_q, puf_en_d;
  logic [RESP_W-1:0]       resp_q, resp_d;
  logic [RESP_W-1:0]       unstable_q, unstable_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    start_acc;

  // Per-bit vote accumulation and final decision terms.
  for (genvar gi = 0; gi < RESP_W; gi++) begin : g_bit
    assign vote_inc[gi] = vote_q[gi] + {3'b000, puf_resp[gi]};
    assign maj_bits[gi] = (vote_q[gi] > VOTE_HALF);
    // Mixed votes: neither all zeros nor all ones.
    assign mix_bits[gi] = (vote_q[gi] != 4'd0) && (vote_q[gi] != VOTE_CNT);
  end

  assign start_acc = start && ena;

  // Next-state and datapath updates; every target defaults to hold.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    eval_cnt_d   = eval_cnt_q;
    vote_d       = vote_q;
    puf_chal_d   = puf_chal_q;
    puf_en_d     = puf_en_q;
    resp_d       = resp_q;
    unstable_d   = unstable_q;
    resp_valid_d = resp_valid_q;

    case (state_q)
      IDLE, DONE: begin
        // A new request wins over ack when both arrive in DONE.
        if (start_acc) begin
          state_d      = SETTLE;
          puf_chal_d   = challenge;
          puf_en_d     = 1'b1;
          settle_cnt_d = '0;
          eval_cnt_d   = '0;
          vote_d       = '0;
          resp_valid_d = 1'b0;
        end else if (state_q == DONE && ack) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      SETTLE: begin
        if (!ena) begin
          state_d  = IDLE;
          puf_en_d = 1'b0;
        end else begin
          settle_cnt_d = settle_cnt_q + 8'd1;
          if (settle_cnt_q == SETTLE_LAST) begin
            vote_d     = vote_inc;
            eval_cnt_d = eval_cnt_q + 4'd1;
            puf_en_d   = 1'b0;
            state_d    = RECOVER;
          end
        end
      end
      RECOVER: begin
        if (!ena) begin
          state_d  = IDLE;
          puf_en_d = 1'b0;
        end else if (eval_cnt_q == VOTE_CNT) begin
          state_d      = DONE;
          resp_d       = maj_bits;
          unstable_d   = mix_bits;
          resp_valid_d = 1'b1;
        end else begin
          state_d      = SETTLE;
          puf_en_d     = 1'b1;
          settle_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      settle_cnt_q <= '0;
      eval_cnt_q   <= '0;
      vote_q       <= '0;
      puf_chal_q   <= '0;
      puf_en_q     <= 1'b0;
      resp_q       <= '0;
      unstable_q   <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      eval_cnt_q   <= eval_cnt_d;
      vote_q       <= vote_d;
      puf_chal_q   <= puf_chal_d;
      puf_en_q     <= puf_en_d;
      resp_q       <= resp_d;
      unstable_q   <= unstable_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign busy       = (state_q == SETTLE) || (state_q == RECOVER);
  assign puf_chal   = puf_chal_q;
  assign puf_en     = puf_en_q;
  assign resp       = resp_q;
  assign unstable   = unstable_q;
  assign resp_valid = resp_valid_q;

endmodule

// File: tb/tb_puf_eval_sequencer.sv
// Testbench for puf_eval_sequencer: randomized per-evaluation PUF responses
// checked against a vote-counting reference model and the cycle timing rules.
module tb_puf_eval_sequencer;

  localparam int CHAL_W = 8;
  localparam int RESP_W = 8;
  localparam int S      = 4;
  localparam int V      = 5;
  localparam int RUN    = V * (S + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ena;
  logic              start;
  logic [CHAL_W-1:0] challenge;
  logic              ack;
  logic [CHAL_W-1:0] puf_chal;
  logic              puf_en;
  logic [RESP_W-1:0] puf_resp;
  logic              busy;
  logic [RESP_W-1:0] resp;
  logic [RESP_W-1:0] unstable;
  logic              resp_valid;

  puf_eval_sequencer #(
    .CHAL_W(CHAL_W), .RESP_W(RESP_W), .SETTLE_CYCLES(S), .VOTE_N(V)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .challenge(challenge),
    .ack(ack), .puf_chal(puf_chal), .puf_en(puf_en), .puf_resp(puf_resp),
    .busy(busy), .resp(resp), .unstable(unstable), .resp_valid(resp_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [RESP_W-1:0] smp [V];
  logic [RESP_W-1:0] exp_resp = '0;
  logic [RESP_W-1:0] exp_unst = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: count ones per bit across the sampled evaluations.
  function automatic void model();
    int c;
    for (int b = 0; b < RESP_W; b++) begin
      c = 0;
      for (int k = 0; k < V; k++) c += int'(smp[k][b]);
      exp_resp[b] = (c > V / 2);
      exp_unst[b] = (c != 0) && (c != V);
    end
  endfunction

  task automatic randomize_samples();
    logic [RESP_W-1:0] base;
    base = RESP_W'($urandom);
    for (int k = 0; k < V; k++) smp[k] = base ^ RESP_W'($urandom & $urandom & $urandom);
  endtask

  // Full request: accept edge, per-cycle enable/busy checks, then the result.
  task automatic run_eval(input logic [CHAL_W-1:0] chal, input bit lockout, input bit with_ack);
    model();
    challenge = chal;
    start     = 1'b1;
    ack       = with_ack;
    puf_resp  = smp[0];
    @(posedge clk); #1;
    start = 1'b0;
    ack   = 1'b0;
    for (int t = 0; t < RUN; t++) begin
      puf_resp = smp[t / (S + 1)];
      if (lockout && (t == 2 || t == 19)) begin
        start     = 1'b1;
        challenge = CHAL_W'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      check_eq("run_puf_en", 32'(puf_en), 32'((t % (S + 1)) < S));
      check_eq("run_busy", 32'(busy), 32'd1);
      check_eq("run_valid", 32'(resp_valid), 32'd0);
      check_eq("run_chal", 32'(puf_chal), 32'(chal));
      @(posedge clk); #1;
    end
    start = 1'b0;
    @(negedge clk);
    check_eq("done_valid", 32'(resp_valid), 32'd1);
    check_eq("done_busy", 32'(busy), 32'd0);
    check_eq("done_puf_en", 32'(puf_en), 32'd0);
    check_eq("done_resp", 32'(resp), 32'(exp_resp));
    check_eq("done_unstable", 32'(unstable), 32'(exp_unst));
    check_eq("done_chal", 32'(puf_chal), 32'(chal));
    $display("run chal=%02h resp=%02h unstable=%02h (model %02h/%02h)",
             chal, resp, unstable, exp_resp, exp_unst);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    @(negedge clk);
    check_eq("ack_valid", 32'(resp_valid), 32'd0);
    check_eq("ack_resp_held", 32'(resp), 32'(exp_resp));
    check_eq("ack_unst_held", 32'(unstable), 32'(exp_unst));
    $display("ack resp_valid=%0b resp=%02h", resp_valid, resp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; ack = 1'b0;
    challenge = '0; puf_resp = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_puf_chal", 32'(puf_chal), 32'd0);
    check_eq("rst_puf_en", 32'(puf_en), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_resp", 32'(resp), 32'd0);
    check_eq("rst_unstable", 32'(unstable), 32'd0);
    check_eq("rst_valid", 32'(resp_valid), 32'd0);
    $display("reset released");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Clean run with a steady response.
    for (int k = 0; k < V; k++) smp[k] = 8'hA5;
    run_eval(8'h3C, 1'b0, 1'b0);
    check_eq("clean_resp_const", 32'(resp), 32'h000000A5);
    check_eq("clean_unst_const", 32'(unstable), 32'h00000000);
    do_ack();
    @(posedge clk); #1;

    // Noisy bits 0 and 7.
    smp = '{8'h01, 8'h80, 8'h01, 8'h00, 8'h01};
    run_eval(8'h5A, 1'b0, 1'b0);
    check_eq("noisy_resp_const", 32'(resp), 32'h00000001);
    check_eq("noisy_unst_const", 32'(unstable), 32'h00000081);
    do_ack();

    // Start pulses while busy must be ignored.
    randomize_samples();
    run_eval(CHAL_W'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("hold_valid", 32'(resp_valid), 32'd1);
      check_eq("hold_busy", 32'(busy), 32'd0);
    end

    // Back-to-back: start together with ack while in DONE.
    randomize_samples();
    run_eval(CHAL_W'($urandom), 1'b0, 1'b1);

    // Random runs, alternating back-to-back and ack-first.
    for (int r = 0; r < 6; r++) begin
      if (r % 2 == 0) begin
        do_ack();
      end
      randomize_samples();
      run_eval(CHAL_W'($urandom), 1'b0, 1'b0);
    end
    do_ack();

    // Abort while settling: no result, previous result retained.
    @(posedge clk); #1;
    challenge = 8'h77;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    ena = 1'b0;
    @(posedge clk); #1;
    ena = 1'b1;
    @(negedge clk);
    check_eq("abort_puf_en", 32'(puf_en), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check_eq("abort_valid", 32'(resp_valid), 32'd0);
    end
    check_eq("abort_resp_held", 32'(resp), 32'(exp_resp));
    check_eq("abort_unst_held", 32'(unstable), 32'(exp_unst));
    $display("abort busy=%0b resp=%02h", busy, resp);

    // Make sure the held result is nonzero so the reset clear is visible.
    smp = '{8'hF3, 8'hF3, 8'hF1, 8'hF3, 8'h73};
    run_eval(8'hC4, 1'b0, 1'b0);
    do_ack();

    // Asynchronous reset in the middle of a settle window.
    @(posedge clk); #1;
    challenge = 8'h9E;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("areset_puf_chal", 32'(puf_chal), 32'd0);
    check_eq("areset_puf_en", 32'(puf_en), 32'd0);
    check_eq("areset_busy", 32'(busy), 32'd0);
    check_eq("areset_resp", 32'(resp), 32'd0);
    check_eq("areset_unstable", 32'(unstable), 32'd0);
    check_eq("areset_valid", 32'(resp_valid), 32'd0);
    $display("async reset asserted mid-run");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    randomize_samples();
    run_eval(CHAL_W'($urandom), 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/puf_eval_sequencer.md
# puf_eval_sequencer

Sequencer that owns the multi-bit PUF array inside the wrapper. It captures one challenge, then runs VOTE_N evaluations of the array. Each evaluation drives the challenge, waits a settle window, samples the response and releases the array for one cycle. It outputs the per-bit majority-voted response plus an unstable-bit mask through a valid/ack handshake toward the host-facing I/O logic.

## Interface
Parameters:
- CHAL_W, 8, challenge width
- RESP_W, 8, PUF response width
- SETTLE_CYCLES, 4, cycles `puf_en` is high before sampling; legal range 1..255
- VOTE_N, 5, evaluations per request; must be odd, legal range 1..15

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous and active-low
- ena  in  1  design enable; low aborts any run
- start  in  1  request pulse; sampled only when `ena`=1
- challenge  in  CHAL_W  challenge, captured on the accepting edge
- ack  in  1  host consumed the result
- puf_chal  out  CHAL_W  challenge driven to the PUF array
- puf_en  out  1  PUF array enable/excite
- puf_resp  in  RESP_W  raw PUF array response; assumed stable by the end of the settle window
- busy  out  1  evaluation in progress
- resp  out  RESP_W  majority-voted response
- unstable  out  RESP_W  bit=1 where the votes were not unanimous
- resp_valid  out  1  `resp`/`unstable` hold a new result

## Operation
- States: IDLE, SETTLE, RECOVER, DONE.
- **IDLE**
  - `start`&`ena` → SETTLE.
  - Latch `challenge` into `puf_chal`; set `puf_en`←1.
  - Clear settle_cnt, eval_cnt and the per-bit vote counters. Vote counters are RESP_W × 4 bits wide.
- **SETTLE**
  - settle_cnt increments each edge.
  - On the edge where settle_cnt==SETTLE_CYCLES-1:
    - add `puf_resp[i]` to vote[i] for every bit;
    - increment eval_cnt;
    - `puf_en`←0;
    - → RECOVER.
- **RECOVER** (exactly 1 cycle)
  - If eval_cnt==VOTE_N: → DONE, with
    - `resp[i]`←(vote[i] > VOTE_N/2);
    - `unstable[i]`←(vote[i]≠0 && vote[i]≠VOTE_N);
    - `resp_valid`←1.
  - Else: → SETTLE, `puf_en`←1, settle_cnt←0.
- **DONE**
  - `resp_valid` held at 1.
  - `start`&`ena` → SETTLE, with the same actions as the IDLE accept and `resp_valid`←0. `start` has priority over `ack`.
  - Else `ack` → IDLE with `resp_valid`←0.
- **Busy and result holding**
  - `busy`=1 exactly in SETTLE and RECOVER.
  - `start` is ignored while busy.
  - `resp`/`unstable` keep their last values until the next completion; they are not cleared by `ack`.
  - `puf_chal` holds its value after a run completes.
- **Abort:** `ena`=0 in SETTLE/RECOVER → IDLE on the next edge.
  - `puf_en`←0; no result is produced.
  - `resp_valid` stays 0; the previous `resp`/`unstable` are kept.
  - `ena`=0 in DONE does not drop the result.

## Timing
- **Reset values:**
  - `puf_chal`=0, `puf_en`=0, `busy`=0, `resp`=0, `unstable`=0, `resp_valid`=0;
  - state IDLE, all counters 0.
  - Reset is asynchronous and takes effect mid-run.
- **Latency:**
  - Start accepted at edge E0.
  - `puf_en` is high for SETTLE_CYCLES cycles per evaluation, then low for 1 cycle.
  - Samples are taken at edges E0+k·(SETTLE_CYCLES+1)−1, for k=1..VOTE_N.
  - `resp_valid` rises at edge E0+VOTE_N·(SETTLE_CYCLES+1). Defaults: E0+25, samples at E4, E9, E14, E19, E24.
- `ack` in DONE: `resp_valid` falls at the same edge.
- **Back-to-back:** `start` in DONE → `busy` rises and `resp_valid` falls at that edge. The next result arrives exactly VOTE_N·(SETTLE_CYCLES+1) cycles later.
- **VOTE_N=1:** `unstable` is always 0.

## Test plan
- **Clean run:** defaults, `challenge`=0x3C, `puf_resp` held at 0xA5, `start` at E0.
  - `puf_chal`=0x3C from E0.
  - `puf_en` pattern is 4 high / 1 low ×5.
  - `resp_valid` rises at E0+25 with `resp`=0xA5, `unstable`=0x00.
  - `ack` → `resp_valid`=0 next edge.
- **Noisy bits:** defaults, base `puf_resp`=0x00 with only these bits varied.
  - bit0 sampled 1,0,1,0,1; bit7 sampled 0,1,0,0,0; all other bits 0.
  - Expect `resp`=0x01, `unstable`=0x81.
- **Busy lockout:** `start` pulses at E0+3 and E0+20 are ignored. Exactly one result appears, at E0+25.
- **Start in DONE with `ack`:** `start`=`ack`=1 in DONE.
  - New run starts; `resp_valid`=0 and `busy`=1 after that edge.
  - Second result appears 25 cycles later.
- **Abort:** `ena`=0 at E0+10 (SETTLE).
  - Next edge: IDLE, `puf_en`=0, `busy`=0.
  - `resp_valid` never rises; `resp` keeps its old value.
- **Async reset:** `rst_n` low at E0+12 (mid-SETTLE), between clock edges.
  - All outputs go to 0 immediately.
  - After release, a fresh `start` completes normally at +25.
